// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: the prefetch queue entry layout,
// PC increment, default reset vector and a saturating add used by the optional statistics counters.
package cpu_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          PC_INC           = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_queue_pc_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of fetch_entry_t with push, pop and flush.
// The pointers carry one extra wrap bit so a full queue and an empty queue are distinguishable.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_push_data,
  output fetch_entry_t             o_head_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  fetch_entry_t     r_mem [DEPTH];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (i_reset || i_flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
    end
  end

  // NOTE: the storage array has no reset; an entry is only read once its pointer says it was written.
  always_ff @(posedge Clk) begin
    if (i_push) r_mem[r_tail[IDX_W-1:0]] <= i_push_data;
  end

  assign o_head_data = r_mem[r_head[IDX_W-1:0]];
  assign o_count     = r_tail - r_head;

endmodule

// File: rtl/fetch_queue_pc.sv
// fetch_queue_pc: PC generator with one-outstanding imem handshake and epoch-tagged prefetch queue.
// Optional statistics counters (stat_fetched, stat_flushed) are built when FETCH_STATS_EN is defined.
module fetch_queue_pc
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT[ADDR_W-1:0]
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              pc_write,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              deq,
  output logic              instr_valid,
  output logic [31:0]       instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              queue_full
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_flushed
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_imem_addr;
  logic              r_imem_req;
  logic              r_epoch;
  logic              r_out_tag;
  logic              r_outstanding;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_inflight;
  logic              w_valid;
  logic              w_resp;
  logic              w_enq;
  logic              w_pop;
  logic              w_issue;
  fetch_entry_t      w_push_entry;
  fetch_entry_t      w_head_entry;
  logic              w_unused;

  assign w_valid    = (w_count != '0);
  assign w_inflight = {1'b0, w_count} + {{CNT_W{1'b0}}, r_outstanding};

  // A response belongs to us only while a request is outstanding; stale epochs and redirect cycles drop it.
  assign w_resp  = imem_rvalid && r_outstanding;
  assign w_enq   = w_resp && (r_out_tag == r_epoch) && !redirect_valid;
  assign w_pop   = deq && w_valid && !redirect_valid;
  assign w_issue = pc_write && !r_outstanding && !redirect_valid
                && (w_inflight < (CNT_W + 1)'(DEPTH));

  assign w_push_entry.pc    = 32'(r_imem_addr);
  assign w_push_entry.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk         (Clk),
    .i_reset     (reset),
    .i_push      (w_enq),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .i_push_data (w_push_entry),
    .o_head_data (w_head_entry),
    .o_count     (w_count)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_imem_addr   <= '0;
      r_imem_req    <= 1'b0;
      r_epoch       <= 1'b0;
      r_out_tag     <= 1'b0;
      r_outstanding <= 1'b0;
    end else begin
      r_imem_req <= w_issue;
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        r_epoch    <= ~r_epoch;
      end else if (w_issue) begin
        r_fetch_pc  <= r_fetch_pc + ADDR_W'(PC_INC);
        r_imem_addr <= r_fetch_pc;
        r_out_tag   <= r_epoch;
      end
      if (w_issue)          r_outstanding <= 1'b1;
      else if (imem_rvalid) r_outstanding <= 1'b0;
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr_valid = w_valid;
  assign instr_out   = w_valid ? w_head_entry.instr : '0;
  assign instr_pc    = w_valid ? w_head_entry.pc[ADDR_W-1:0] : '0;
  assign queue_full  = (w_count == CNT_W'(DEPTH));
  assign w_unused    = ^{1'b0, redirect_pc[1:0]};

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_fetched;
  logic [31:0] r_stat_flushed;
  logic [31:0] w_flush_inc;

  assign w_flush_inc = (redirect_valid ? 32'(w_count) : 32'd0)
                     + ((w_resp && !w_enq) ? 32'd1 : 32'd0);

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_stat_fetched <= '0;
      r_stat_flushed <= '0;
    end else begin
      if (w_enq) r_stat_fetched <= sat_add32(r_stat_fetched, 32'd1);
      r_stat_flushed <= sat_add32(r_stat_flushed, w_flush_inc);
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_flushed = r_stat_flushed;
`endif

endmodule

// File: doc/fetch_queue_pc.md
Name: fetch_queue_pc

Overview:
Parametrised successor to the single-register program counter. It generates sequential fetch addresses and issues word requests to the instruction memory over a one-outstanding request/response handshake. Returned words are buffered, together with their PC, in a DEPTH-entry prefetch queue that decode drains. Branch/jump redirects flush the queue and discard any stale in-flight response. The block sits between the hazard unit (pc_write stall) and decode.

Parameters:
ADDR_W, 32, width of PC and memory address
DEPTH, 4, prefetch queue entries (power of two, >= 2)
RESET_PC, 32'h00000000, PC loaded on reset

Ports:
Clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high
pc_write  input  1  1 = fetch may advance; 0 = freeze request issue (queue still drains)
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  ADDR_W  new fetch target
imem_req  output  1  request valid, registered
imem_addr  output  ADDR_W  word address of request, low 2 bits always 0
imem_rvalid  input  1  response valid, exactly 1 cycle after the accepted request
imem_rdata  input  32  instruction word, big-endian byte order
deq  input  1  decode consumes the head entry this cycle
instr_valid  output  1  queue non-empty
instr_out  output  32  head instruction
instr_pc  output  ADDR_W  PC of head instruction
queue_full  output  1  count == DEPTH

Behaviour:
- Reset (sync): fetch_pc = RESET_PC; queue empty; imem_req = 0; epoch = 0; instr_valid = 0; queue_full = 0; instr_out and instr_pc = 0.
- Issue rule: imem_req is asserted next cycle when all of the following hold: pc_write = 1, no request is outstanding, (count + outstanding) < DEPTH, and redirect_valid = 0. On issue: imem_addr = fetch_pc and fetch_pc += 4. Wrap-around is modulo 2^ADDR_W.
- One outstanding request only. An issued request tags the current epoch. The matching imem_rvalid enqueues {fetch address, imem_rdata} at the tail only if its tag equals the current epoch; otherwise it is dropped.
- Latency: a request issued in cycle N returns in N+1 and is visible on instr_valid/instr_out in N+2.
- deq with instr_valid = 1 pops the head. deq with instr_valid = 0 is ignored. Simultaneous enqueue and dequeue keeps count unchanged. The enqueue guard (count + outstanding < DEPTH) prevents overflow; an enqueue is never dropped for lack of space.
- Redirect, cycle R:
  - queue flushed (count = 0, head/tail reset);
  - epoch toggles;
  - fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  - no issue in cycle R;
  - a response arriving in R or R+1 that carries the old tag is dropped;
  - redirect has priority over deq, enqueue and pc_write.
- pc_write = 0 freezes fetch_pc and request issue. An outstanding response still enqueues, and deq still pops.
- Reset mid-operation: an outstanding response arriving after reset is dropped. Reset clears the outstanding flag and toggles nothing; the bench sees no enqueue in the cycle after reset.
- The queue is implemented as a circular buffer with log2(DEPTH)+1-bit head/tail pointers (wrap bit distinguishes full from empty).

Optional Feature:
FETCH_STATS_EN
- Defined: adds two 32-bit output counters.
  - stat_fetched increments on each accepted enqueue.
  - stat_flushed increments by the number of entries discarded on redirect, plus 1 for each dropped stale response.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - INSTR_W = 32, PC_INC = 4, RESET_PC_DEFAULT;
  - typedef fetch_entry_t {pc, instr}.
- One natural sub-module: fetch_fifo, a parametrised DEPTH x fetch_entry_t circular buffer with push/pop/flush and count output. fetch_queue_pc owns the PC, epoch and handshake.

Test Plan:
1. Reset, then pc_write = 1, deq = 0, memory returns addr-as-data -> requests to 0x0, 0x4, 0x8, 0xC; queue_full = 1 after the 4th response; no 5th request while full.
2. With steady deq = 1 -> instr_pc sequence 0x0, 0x4, 0x8, ... with instr_out matching; instr_valid first high 2 cycles after the first imem_req.
3. Redirect to 0x2A while a request for 0x10 is outstanding -> 0x10 response dropped, queue empty, next imem_addr = 0x28, first instr_pc = 0x28.
4. pc_write = 0 for 5 cycles with one request outstanding -> that response enqueues, no new imem_req, fetch_pc unchanged; resumes at the next address when pc_write returns to 1.
5. redirect_valid, deq and imem_rvalid in the same cycle -> queue empty next cycle, count = 0, no enqueue.
6. RESET_PC = 32'hFFFFFFF8 -> fetch sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
